// File: rtl/cdc_wr_arbiter_pkg.sv
// Shared types and widths for the round-robin write-port arbiter.
package cdc_wr_arbiter_pkg;
    localparam int GID_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Next requester index after idx, wrapping at n.
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + GID_W'(1);
    endfunction
endpackage

// File: rtl/cdc_wr_arbiter_if.sv
// Requester side and FIFO write side of the arbiter, bundled as one interface.
interface cdc_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    import cdc_wr_arbiter_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               wfull;
    logic               winc;
    logic [DW-1:0]      wdata;
    logic               busy;
    logic [GID_W-1:0]   grant_id;
    logic [CNT_W-1:0]   beat_cnt;

    modport master (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, busy, grant_id, beat_cnt
    );

    modport slave (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, busy, grant_id, beat_cnt
    );
endinterface

// File: rtl/cdc_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, modulo NREQ.
module cdc_wr_arbiter_rr_pick
    import cdc_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] rr_ptr,
    output logic [GID_W-1:0] idx,
    output logic             any_req
);
    logic [GID_W-1:0] cand [NREQ];
    logic [NREQ-1:0]  rot;

    // rot[k] is the request of the requester k positions after rr_ptr.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [GID_W:0] sum;
        assign sum      = {1'b0, rr_ptr} + (GID_W+1)'(gi);
        assign cand[gi] = (sum >= (GID_W+1)'(NREQ)) ? GID_W'(sum - (GID_W+1)'(NREQ))
                                                     : sum[GID_W-1:0];
        assign rot[gi]  = |(req & (NREQ'(1) << cand[gi]));
    end

    always_comb begin
        idx     = '0;
        any_req = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = cand[k];
            end
        end
    end
endmodule

// File: rtl/cdc_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ requesters.
module cdc_wr_arbiter
    import cdc_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    cdc_wr_arbiter_if.master bus
);
    state_t           state_reg, state_next;
    logic [GID_W-1:0] grant_reg, grant_next;
    logic [GID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [GID_W-1:0] pick_idx;
    logic             any_req;
    logic [NREQ-1:0]  sel;
    logic             winc_int;
    logic             last_g;
    logic [DW-1:0]    wdata_mux;

    cdc_wr_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr_reg),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
        assign sel[gi] = (grant_reg == GID_W'(gi));
    end

    // Grant is locked: only the granted requester's valid/last matter while BUSY.
    assign winc_int = (state_reg == BUSY) & (|(sel & bus.req_valid)) & ~bus.wfull;
    assign last_g   = |(sel & bus.req_last);

    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel[i]) begin
                wdata_mux = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign bus.winc      = winc_int;
    assign bus.req_ready = winc_int ? sel : '0;
    assign bus.wdata     = winc_int ? wdata_mux : '0;
    assign bus.busy      = (state_reg == BUSY);
    assign bus.grant_id  = grant_reg;
    assign bus.beat_cnt  = beat_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = BUSY;
                    grant_next    = pick_idx;
                    beat_cnt_next = '0;
                end
            end
            BUSY: begin
                if (winc_int) begin
                    // last and the burst limit on the same beat give one release.
                    if (last_g || (beat_cnt_reg == CNT_W'(MAX_BURST - 1))) begin
                        state_next    = IDLE;
                        rr_ptr_next   = wrap_inc(grant_reg, NREQ);
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Directed and randomized bench for cdc_wr_arbiter against a transaction-level model.
module tb_cdc_wr_arbiter;
    import cdc_wr_arbiter_pkg::*;

    localparam int NREQ      = 4;
    localparam int DW        = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdc_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    cdc_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Per-requester pending beats: bit DW is the last flag, low bits are data.
    logic [DW:0] srcq [NREQ][$];
    bit          hold [NREQ];
    bit          full_drv;

    // Model: owner (-1 when no grant), last granted id, round-robin pointer, beats in grant.
    int m_owner, m_gid, m_ptr, m_cnt;

    int obs_grants[$], obs_writes[$], obs_lens[$];
    int obs_len;
    bit prev_busy;
    int exp_q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(string tag, int q[$], int e[$]);
        chk({tag, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int k = 0; k < e.size(); k++) begin
            chk(tag, (k < q.size()) ? 32'(q[k]) : 32'hFFFF_FFFF, 32'(e[k]));
        end
    endtask

    function automatic bit src_valid(int i);
        return (srcq[i].size() > 0) && !hold[i];
    endfunction

    task automatic drive();
        logic [DW:0] h;
        for (int i = 0; i < NREQ; i++) begin
            h = (srcq[i].size() > 0) ? srcq[i][0] : '0;
            bus.req_valid[i]           = src_valid(i);
            bus.req_data[i*DW +: DW]   = h[DW-1:0];
            bus.req_last[i]            = h[DW];
        end
        bus.wfull = full_drv;
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_ready;
        logic            e_winc;
        logic [DW:0]     h;
        logic [DW-1:0]   e_wdata;
        e_ready = '0;
        e_winc  = 1'b0;
        e_wdata = '0;
        if (m_owner >= 0 && src_valid(m_owner) && !full_drv) begin
            h = srcq[m_owner][0];
            e_winc = 1'b1;
            e_ready[m_owner] = 1'b1;
            e_wdata = h[DW-1:0];
        end
        chk("winc", 32'(bus.winc), 32'(e_winc));
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("wdata", 32'(bus.wdata), 32'(e_wdata));
        chk("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
    endtask

    task automatic model_update();
        logic [DW:0] b;
        bit found;
        int j;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!found && src_valid(j)) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_gid   = j;
                    m_cnt   = 0;
                end
            end
        end else if (src_valid(m_owner) && !full_drv) begin
            b = srcq[m_owner].pop_front();
            m_cnt++;
            if (b[DW] || m_cnt == MAX_BURST) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        if (bus.busy && !prev_busy) obs_grants.push_back(int'(bus.grant_id));
        if (bus.winc === 1'b1) begin
            obs_writes.push_back(int'(bus.grant_id) * 16 + int'(bus.wdata));
            obs_len++;
        end
        if (!bus.busy && prev_busy) begin
            obs_lens.push_back(obs_len);
            obs_len = 0;
        end
        prev_busy = bus.busy;
        model_update();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_obs();
        obs_grants.delete();
        obs_writes.delete();
        obs_lens.delete();
        obs_len   = 0;
        prev_busy = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gid   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_winc"}, 32'(bus.winc), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_beat_cnt"}, 32'(bus.beat_cnt), 32'd0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
    endtask

    task automatic do_reset(string tag);
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete();
            hold[i] = 1'b0;
        end
        full_drv = 1'b0;
        drive();
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic push_burst(int id, int len, int first_data);
        for (int k = 0; k < len; k++) begin
            srcq[id].push_back({(k == len - 1) ? 1'b1 : 1'b0, DW'(first_data + k)});
        end
    endtask

    function automatic bit work_pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic run_until_idle(string tag, int budget);
        int c;
        c = 0;
        drive();
        while (work_pending() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_timeout"}, 32'(work_pending()), 32'd0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        full_drv = 1'b0;
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        model_reset();
        clear_obs();
        drive();
        #2;
        do_reset("rst_init");

        // Single requester burst A,B,C from requester 1.
        push_burst(1, 3, 'hA);
        run_until_idle("single", 50);
        exp_q = '{1};
        chk_q("single_grants", obs_grants, exp_q);
        exp_q = '{'h1A, 'h1B, 'h1C};
        chk_q("single_writes", obs_writes, exp_q);
        exp_q = '{3};
        chk_q("single_lens", obs_lens, exp_q);

        // Round-robin rotation with single-beat bursts.
        do_reset("rst_rr");
        push_burst(0, 1, 1); push_burst(0, 1, 2);
        push_burst(1, 1, 3); push_burst(1, 1, 4);
        push_burst(2, 1, 5);
        push_burst(3, 1, 6);
        run_until_idle("rr", 100);
        exp_q = '{0, 1, 2, 3, 0, 1};
        chk_q("rr_grants", obs_grants, exp_q);
        exp_q = '{'h01, 'h13, 'h25, 'h36, 'h02, 'h14};
        chk_q("rr_writes", obs_writes, exp_q);

        // Reset mid-burst: pointer is at 2 here, requester 3 gets the grant.
        clear_obs();
        push_burst(3, 5, 7);
        drive();
        repeat (3) step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_grant", 32'(bus.grant_id), 32'd3);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        push_burst(1, 2, 1);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_obs();
        run_until_idle("rst_mid", 100);
        exp_q = '{1, 3};
        chk_q("rst_mid_grants", obs_grants, exp_q);
        exp_q = '{'h11, 'h12, 'h39, 'h3A, 'h3B};
        chk_q("rst_mid_writes", obs_writes, exp_q);

        // MAX_BURST release with no other requester: wraps back to 2.
        do_reset("rst_mb1");
        push_burst(2, 10, 0);
        run_until_idle("maxb_wrap", 100);
        exp_q = '{2, 2};
        chk_q("maxb_wrap_grants", obs_grants, exp_q);
        exp_q = '{8, 2};
        chk_q("maxb_wrap_lens", obs_lens, exp_q);

        // MAX_BURST release hands over to requester 3 when it is waiting.
        do_reset("rst_mb2");
        push_burst(2, 9, 0);
        push_burst(3, 1, 5);
        run_until_idle("maxb_next", 100);
        exp_q = '{2, 3, 2};
        chk_q("maxb_next_grants", obs_grants, exp_q);
        exp_q = '{8, 1, 1};
        chk_q("maxb_next_lens", obs_lens, exp_q);

        // Full backpressure for 5 cycles mid-burst.
        do_reset("rst_bp");
        push_burst(0, 6, 1);
        drive();
        repeat (3) step();
        full_drv = 1'b1;
        drive();
        repeat (5) begin
            step();
            chk("bp_cnt_frozen", 32'(bus.beat_cnt), 32'd2);
            chk("bp_winc", 32'(bus.winc), 32'd0);
        end
        full_drv = 1'b0;
        run_until_idle("bp", 50);
        exp_q = '{'h01, 'h02, 'h03, 'h04, 'h05, 'h06};
        chk_q("bp_writes", obs_writes, exp_q);
        exp_q = '{6};
        chk_q("bp_lens", obs_lens, exp_q);

        // Valid gap under lock while requester 1 waits.
        do_reset("rst_gap");
        push_burst(0, 4, 1);
        push_burst(1, 1, 9);
        drive();
        repeat (3) step();
        hold[0] = 1'b1;
        drive();
        repeat (2) begin
            step();
            chk("gap_ready1", 32'(bus.req_ready[1]), 32'd0);
            chk("gap_grant", 32'(bus.grant_id), 32'd0);
        end
        hold[0] = 1'b0;
        run_until_idle("gap", 50);
        exp_q = '{0, 1};
        chk_q("gap_grants", obs_grants, exp_q);
        exp_q = '{4, 1};
        chk_q("gap_lens", obs_lens, exp_q);

        // Randomized traffic with stalls and backpressure against the model.
        do_reset("rst_rand");
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (srcq[i].size() < 4 && $urandom_range(0, 3) == 0)
                    push_burst(i, int'($urandom_range(1, 12)), int'($urandom_range(0, 15)));
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            full_drv = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        full_drv = 1'b0;
        run_until_idle("rand_drain", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
